// File: rtl/butterfly_input_packer.sv
// butterfly_input_packer: collects BEATS AXI beats from every input channel into one wide
// butterfly frame and hands the frame to the processor through a valid/ready handshake.
module butterfly_input_packer #(
  parameter int DATA_WIDTH_AXI          = 256,
  parameter int INPUT_AXI_CHNL          = 8,
  parameter int data_width              = 16,
  parameter int be_parallelism          = 128,
  parameter int parallelism_per_control = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start,
  input  logic [15:0]                                    num_frames,
  input  logic [INPUT_AXI_CHNL-1:0]                      s_vld,
  input  logic [DATA_WIDTH_AXI*INPUT_AXI_CHNL-1:0]       s_dat,
  output logic [INPUT_AXI_CHNL-1:0]                      s_rdy,
  output logic [be_parallelism/parallelism_per_control-1:0] dn_vld,
  output logic [2*data_width*be_parallelism-1:0]         dn_dat,
  input  logic                                           dn_rdy,
  output logic                                           busy,
  output logic                                           done,
  output logic [15:0]                                    frame_cnt
);

  localparam int SLICE  = 2 * data_width * be_parallelism / INPUT_AXI_CHNL;
  localparam int BEATS  = SLICE / DATA_WIDTH_AXI;
  localparam int GROUPS = be_parallelism / parallelism_per_control;
  localparam int DN_W   = 2 * data_width * be_parallelism;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [15:0]               num_frames_q;
  logic [BW-1:0]             beat_cnt [INPUT_AXI_CHNL];
  logic [INPUT_AXI_CHNL-1:0] full;
  logic [DN_W-1:0]           dat_q;
  logic [INPUT_AXI_CHNL-1:0] accept;
  logic                      all_full;
  logic                      fire;

  // Handshake: a beat moves when s_vld[c] & s_rdy[c] at a rising edge; a frame moves when
  // dn_vld & dn_rdy. dn_vld/dn_dat stay stable until taken, and valid never waits on ready.
  assign s_rdy    = {INPUT_AXI_CHNL{state == RUN}} & ~full;
  assign accept   = s_vld & s_rdy;
  assign all_full = &full;
  assign fire     = all_full & dn_rdy;
  assign dn_dat   = dat_q;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Only the first INPUT_AXI_CHNL engine groups are fed by this packer.
  always_comb begin
    dn_vld = '0;
    for (int j = 0; j < GROUPS; j++) begin
      if (j < INPUT_AXI_CHNL) dn_vld[j] = all_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      num_frames_q <= '0;
      frame_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_frames_q <= num_frames;
            frame_cnt    <= '0;
            state        <= (num_frames == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fire) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (frame_cnt == num_frames_q - 16'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A channel is full from its last beat until the frame fires; fire and accept can never
  // coincide on one channel, so the cleared channel refills from the next cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= '0;
      dat_q <= '0;
      for (int c = 0; c < INPUT_AXI_CHNL; c++) beat_cnt[c] <= '0;
    end else begin
      if (fire) full <= '0;
      for (int c = 0; c < INPUT_AXI_CHNL; c++) begin
        if (accept[c]) begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt[c] == BW'(b))
              dat_q[c*SLICE + b*DATA_WIDTH_AXI +: DATA_WIDTH_AXI] <=
                s_dat[c*DATA_WIDTH_AXI +: DATA_WIDTH_AXI];
          end
          if (beat_cnt[c] == BW'(BEATS - 1)) begin
            beat_cnt[c] <= '0;
            full[c]     <= 1'b1;
          end else begin
            beat_cnt[c] <= beat_cnt[c] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_butterfly_input_packer.sv
// Bench for butterfly_input_packer: directed scenarios plus randomized runs, every cycle
// compared against a beat-counting frame model of the packer.
module tb_butterfly_input_packer;

  localparam int AW     = 256;
  localparam int NCH    = 8;
  localparam int DW     = 16;
  localparam int PAR    = 128;
  localparam int PPC    = 4;
  localparam int SLICE  = 2 * DW * PAR / NCH;
  localparam int BEATS  = SLICE / AW;
  localparam int GROUPS = PAR / PPC;
  localparam int DNW    = 2 * DW * PAR;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       num_frames = '0;
  logic [NCH-1:0]    s_vld = '0;
  logic [AW*NCH-1:0] s_dat = '0;
  logic              dn_rdy = 1'b0;
  logic [NCH-1:0]    s_rdy;
  logic [GROUPS-1:0] dn_vld;
  logic [DNW-1:0]    dn_dat;
  logic              busy;
  logic              done;
  logic [15:0]       frame_cnt;

  // clock / reset
  always #5 clk = ~clk;

  butterfly_input_packer #(
    .DATA_WIDTH_AXI(AW), .INPUT_AXI_CHNL(NCH), .data_width(DW),
    .be_parallelism(PAR), .parallelism_per_control(PPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_frames(num_frames),
    .s_vld(s_vld), .s_dat(s_dat), .s_rdy(s_rdy),
    .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_rdy(dn_rdy),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: a run is a count of frames; a frame is complete once every channel
  // has delivered BEATS beats; a full channel takes nothing until the frame is handed over.
  bit             m_run;
  bit             m_done;
  int             m_cnt [NCH];
  logic [DNW-1:0] m_dat;
  int             m_frames;
  int             m_target;
  logic [NCH-1:0] m_acc;
  bit             m_fire;
  logic [GROUPS-1:0] exp_vld;

  function automatic logic [NCH-1:0] exp_s_rdy();
    logic [NCH-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) r[c] = m_run && (m_cnt[c] < BEATS);
    return r;
  endfunction

  function automatic bit exp_full();
    bit f;
    f = m_run;
    for (int c = 0; c < NCH; c++) if (m_cnt[c] != BEATS) f = 1'b0;
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_frames = 0; m_target = 0; m_dat = '0;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    end else begin
      m_acc  = exp_s_rdy() & s_vld;
      m_fire = exp_full() && dn_rdy;
      if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        for (int c = 0; c < NCH; c++) begin
          if (m_acc[c]) begin
            m_dat[c*SLICE + m_cnt[c]*AW +: AW] = s_dat[c*AW +: AW];
            m_cnt[c]++;
          end
        end
        if (m_fire) begin
          for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
          m_frames++;
          if (m_frames == m_target) begin
            m_run = 0;
            m_done = 1;
          end
        end
      end else if (start) begin
        m_frames = 0;
        m_target = int'(num_frames);
        if (num_frames == 16'd0) m_done = 1;
        else m_run = 1;
      end
    end
  end

  // scoreboard: every output against the model on each falling edge out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      exp_vld = '0;
      if (exp_full()) exp_vld[NCH-1:0] = '1;
      check("s_rdy", 64'(s_rdy), 64'(exp_s_rdy()));
      check("dn_vld", 64'(dn_vld), 64'(exp_vld));
      check("busy", 64'(busy), 64'(m_run || m_done));
      check("done", 64'(done), 64'(m_done));
      check("frame_cnt", 64'(frame_cnt), 64'(16'(m_frames)));
      checks++;
      if (dn_dat !== m_dat) begin
        errors++;
        for (int i = 0; i < DNW / AW; i++) begin
          if (dn_dat[i*AW +: AW] !== m_dat[i*AW +: AW]) begin
            $display("FAIL dn_dat word %0d actual=%h expected=%h", i, dn_dat[i*AW +: AW], m_dat[i*AW +: AW]);
            break;
          end
        end
      end
      if (done === 1'b1) done_seen++;
    end
  end

  // driver tasks
  task automatic pulse_start(input int nf);
    @(negedge clk);
    start = 1'b1;
    num_frames = 16'(nf);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_data();
    for (int c = 0; c < NCH; c++)
      for (int w = 0; w < AW / 32; w++) s_dat[c*AW + w*32 +: 32] = $urandom();
  endtask

  task automatic run_frames(input int nf, input int vld_pct, input int rdy_pct,
                            input int slow_ch, input int slow_delay, input int stray_at);
    int d0, cyc, since, last;
    d0 = done_seen;
    pulse_start(nf);
    cyc = 0; since = 0; last = 0;
    while ((m_run || m_done) && cyc < 5000) begin
      if (m_frames != last) begin
        last = m_frames;
        since = 0;
      end
      for (int c = 0; c < NCH; c++) s_vld[c] = ($urandom_range(99) < vld_pct);
      if (slow_ch >= 0 && since < slow_delay) s_vld[slow_ch] = 1'b0;
      rand_data();
      dn_rdy = ($urandom_range(99) < rdy_pct);
      if (cyc == stray_at) begin
        start = 1'b1;
        num_frames = 16'd7;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      since++;
    end
    s_vld = '0;
    dn_rdy = 1'b0;
    if (cyc >= 5000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=%0d cycles required=<5000", cyc);
    end
    @(negedge clk);
    check("run_frame_cnt", 64'(frame_cnt), 64'(nf));
    check("model_frames", 64'(m_frames), 64'(nf));
    check("run_done_pulses", 64'(done_seen - d0), 64'd1);
    check("run_idle", 64'(busy), 64'd0);
  endtask

  logic [7:0] b0, b1;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_s_rdy", 64'(s_rdy), 64'd0);
    check("rst_dn_vld", 64'(dn_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // one frame, beats 0xA../0xB.. back to back, processor always ready
    pulse_start(1);
    dn_rdy = 1'b1;
    s_vld = '1;
    for (int c = 0; c < NCH; c++) begin
      b0 = 8'hA0 | 8'(c);
      s_dat[c*AW +: AW] = {32{b0}};
    end
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      b1 = 8'hB0 | 8'(c);
      s_dat[c*AW +: AW] = {32{b1}};
    end
    @(negedge clk);
    s_vld = '0;
    check("one_dn_vld", 64'(dn_vld), 64'h0000_00FF);
    for (int c = 0; c < NCH; c++) begin
      b0 = 8'hA0 | 8'(c);
      b1 = 8'hB0 | 8'(c);
      checks++;
      if (dn_dat[c*SLICE +: SLICE] !== {{32{b1}}, {32{b0}}}) begin
        errors++;
        $display("FAIL one_slice%0d actual=%h expected=%h", c, dn_dat[c*SLICE + SLICE - 64 +: 64], {{8{b1}}});
      end
    end
    @(negedge clk);
    check("one_done", 64'(done), 64'd1);
    check("one_frame_cnt", 64'(frame_cnt), 64'd1);
    check("one_dn_vld_low", 64'(dn_vld), 64'd0);
    @(negedge clk);
    check("one_done_low", 64'(done), 64'd0);
    dn_rdy = 1'b0;

    // channel 5 lags each frame by 10 cycles
    run_frames(3, 100, 100, 5, 10, -1);

    // processor stalls 20 cycles on a full frame
    pulse_start(1);
    dn_rdy = 1'b0;
    s_vld = '1;
    rand_data();
    repeat (BEATS) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("stall_s_rdy", 64'(s_rdy), 64'd0);
      check("stall_dn_vld", 64'(dn_vld), 64'h0000_00FF);
      rand_data();
      @(negedge clk);
    end
    dn_rdy = 1'b1;
    @(negedge clk);
    dn_rdy = 1'b0;
    s_vld = '0;
    check("stall_done", 64'(done), 64'd1);
    check("stall_frame_cnt", 64'(frame_cnt), 64'd1);
    @(negedge clk);

    // zero-frame run
    pulse_start(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_s_rdy", 64'(s_rdy), 64'd0);
    check("zero_dn_vld", 64'(dn_vld), 64'd0);
    @(negedge clk);
    check("zero_done_low", 64'(done), 64'd0);
    check("zero_frame_cnt", 64'(frame_cnt), 64'd0);

    // reset after one beat of frame 2
    pulse_start(3);
    dn_rdy = 1'b1;
    s_vld = '1;
    rand_data();
    repeat (BEATS) @(negedge clk);
    s_vld = '0;
    @(negedge clk);
    s_vld = 8'h01;
    rand_data();
    @(negedge clk);
    s_vld = '0;
    dn_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_s_rdy", 64'(s_rdy), 64'd0);
    check("mrst_dn_vld", 64'(dn_vld), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("mrst_dn_dat_zero", 64'(dn_dat != '0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frames(1, 70, 70, -1, 0, -1);

    // start during RUN is ignored
    run_frames(4, 80, 80, -1, 0, 3);

    // randomized runs
    for (int r = 0; r < 15; r++)
      run_frames($urandom_range(1, 4), $urandom_range(30, 100), $urandom_range(30, 100), -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
